threshold_compress_ctrl: RTL and testbench
==========================================

Name: threshold_compress_ctrl

Overview:
Sequencer for the ternary threshold_compress datapath. Pulls 32-bit preactivations from an upstream valid/ready stream. Feeds them in groups of TRITS_PER_GROUP to the compressor, with the matching per-group threshold pair from a local table. Collects each compressed byte and packs bytes little-endian into 32-bit words for a downstream valid/ready writeback stream.

Parameters:
OUTPUT_WIDTH, 8, compressed output width per group (compressor data_o width)
TRITS_PER_GROUP, 5, preactivations per compressed group
N_THRESH, 16, threshold table entries (power of 2)
AW, $clog2(N_THRESH), table address width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cfg_we_i  in  1  threshold table write strobe
cfg_addr_i  in  AW  table write address
cfg_thr_i  in  32  threshold pair {hi[31:16], lo[15:0]}
start_i  in  1  start job (sampled in IDLE only)
n_groups_i  in  16  groups (output bytes) in job, sampled on start
thr_base_i  in  AW  first table index, sampled on start
pre_valid_i  in  1  preactivation valid
pre_ready_o  out  1  preactivation ready
pre_data_i  in  32  preactivation
comp_data_o  out  32  to compressor data_i
comp_thr_o  out  32  to compressor threshold_i
comp_enable_o  out  1  to compressor enable_i
comp_data_i  in  OUTPUT_WIDTH  from compressor data_o
comp_ready_i  in  1  from compressor ready_o
out_valid_o  out  1  packed word valid
out_ready_i  in  1  packed word ready
out_data_o  out  32  packed word
out_last_o  out  1  final word of job
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse at job end

Behaviour:
- Reset: state IDLE; all outputs 0; counters and pack register 0; table cleared to 0.
- Table: written when cfg_we_i and state==IDLE; writes outside IDLE are ignored.
- FSM states are IDLE, FEED, WAIT, EMIT and DONE.
- IDLE: on start_i, latch n_groups_i, thr_base_i into thr_idx, grp_cnt=0, trit_cnt=0, byte_cnt=0.
  - Go to FEED, or to DONE if n_groups_i==0.
- FEED:
  - pre_ready_o=1, combinational on state; 0 in all other states.
  - On handshake, register comp_data_o<=pre_data_i and comp_enable_o<=1 for exactly the next cycle.
  - Without a handshake, comp_enable_o<=0.
  - comp_thr_o<=table[thr_idx] is registered and held for the whole group.
  - trit_cnt increments per handshake. On the TRITS_PER_GROUP-th handshake, go to WAIT.
- WAIT: hold comp_enable_o=0.
  - On comp_ready_i, write comp_data_i into pack lane byte_cnt (bits 8*byte_cnt+:8).
  - Then grp_cnt++, thr_idx++ (wraps mod N_THRESH), trit_cnt=0.
  - If lane 3 was filled or grp_cnt reaches n_groups, go to EMIT. Otherwise byte_cnt++ and go to FEED.
- EMIT:
  - out_valid_o=1 with out_data_o = pack register; unfilled lanes are 0.
  - out_last_o=1 iff all groups are done.
  - out_valid_o, out_data_o and out_last_o stay stable until out_ready_i.
  - On handshake, clear pack register and byte_cnt. Go to DONE if last, else FEED.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in every state except IDLE.
- Latency: the first group's byte is captured in the cycle comp_ready_i is seen. A full word is presented the cycle after the 4th capture.
- No pipelining: preactivations are not accepted while in WAIT or EMIT.
- Boundaries:
  - start_i outside IDLE is ignored.
  - comp_ready_i outside WAIT is ignored.
  - n_groups=1 gives one word with lanes 1..3 zero and last=1.
  - n_groups=4k gives exactly k words with no empty trailing word.
  - thr_idx wraps 15→0 for N_THRESH=16.
  - rst_i mid-job aborts immediately to the reset state; no done_o is generated.

Test Plan:
- Table[0]=0x0010FFF0, Table[1]=0x0020FFE0; start n_groups=2, thr_base=0; 10 preactivations; compressor stub returns 0xA0, then 0xA1.
  - Required: comp_thr_o=0x0010FFF0 for group 0 and 0x0020FFE0 for group 1.
  - Required: one word 0x0000A1A0 with last=1, then a done_o pulse.
- n_groups=8 with stub bytes 0x01..0x08.
  - Required: words 0x04030201 (last=0), then 0x08070605 (last=1). Exactly 40 pre handshakes.
- Backpressure: out_ready_i=0 for 6 cycles during EMIT.
  - Required: out_data_o stable, pre_ready_o=0 throughout, no extra comp_enable_o pulses.
- pre_valid_i toggled every other cycle.
  - Required: comp_enable_o pulses only the cycle after each handshake, 5 per group.
- thr_base=15, n_groups=2.
  - Required: thresholds from table[15], then table[0].
  - Required: cfg write during busy leaves table unchanged. start_i during busy is ignored.
- Assert rst_i mid-FEED after 3 preactivations.
  - Required: next cycle all outputs 0, state IDLE, no done_o.
  - Required: a new job then completes normally.

Source files
------------

// File: rtl/threshold_compress_ctrl.sv
// threshold_compress_ctrl: sequences preactivations into the ternary
// threshold compressor and packs its output bytes into 32-bit words.
module threshold_compress_ctrl #(
    parameter int OUTPUT_WIDTH    = 8,
    parameter int TRITS_PER_GROUP = 5,
    parameter int N_THRESH        = 16,
    parameter int AW              = $clog2(N_THRESH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_we_i,
    input  logic [AW-1:0]           cfg_addr_i,
    input  logic [31:0]             cfg_thr_i,
    input  logic                    start_i,
    input  logic [15:0]             n_groups_i,
    input  logic [AW-1:0]           thr_base_i,
    input  logic                    pre_valid_i,
    output logic                    pre_ready_o,
    input  logic [31:0]             pre_data_i,
    output logic [31:0]             comp_data_o,
    output logic [31:0]             comp_thr_o,
    output logic                    comp_enable_o,
    input  logic [OUTPUT_WIDTH-1:0] comp_data_i,
    input  logic                    comp_ready_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [31:0]             out_data_o,
    output logic                    out_last_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        WAIT,
        EMIT,
        DONE
    } state_t;

    localparam int TW = $clog2(TRITS_PER_GROUP + 1);

    state_t          state;
    state_t          state_n;
    logic [31:0]     thr_tab [N_THRESH];
    logic [15:0]     n_groups;
    logic [15:0]     grp_cnt;
    logic [AW-1:0]   thr_idx;
    logic [TW-1:0]   trit_cnt;
    logic [1:0]      byte_cnt;
    logic [31:0]     pack;
    logic            pre_hs;
    logic            last_trit;
    logic            last_grp;
    logic            lane_full;
    logic            all_done;

    assign pre_hs    = (state == FEED) && pre_valid_i;
    assign last_trit = trit_cnt == TW'(TRITS_PER_GROUP - 1);
    assign last_grp  = (grp_cnt + 16'd1) == n_groups;
    assign lane_full = byte_cnt == 2'd3;
    assign all_done  = grp_cnt == n_groups;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and handshake outputs, decoded from the current state
    always_comb begin
        state_n     = state;
        pre_ready_o = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        unique case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i)
                    state_n = (n_groups_i == 16'd0) ? DONE : FEED;
            end
            FEED: begin
                pre_ready_o = 1'b1;
                if (pre_valid_i && last_trit) state_n = WAIT;
            end
            WAIT: begin
                if (comp_ready_i)
                    state_n = (lane_full || last_grp) ? EMIT : FEED;
            end
            EMIT: begin
                out_valid_o = 1'b1;
                out_data_o  = pack;
                out_last_o  = all_done;
                if (out_ready_i) state_n = all_done ? DONE : FEED;
            end
            DONE: begin
                done_o  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Threshold table; only writable while no job is running
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_THRESH; i++) thr_tab[i] <= '0;
        end else if (cfg_we_i && state == IDLE) begin
            thr_tab[cfg_addr_i] <= cfg_thr_i;
        end
    end

    // Job counters, compressor drive and byte packing
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_groups      <= '0;
            grp_cnt       <= '0;
            thr_idx       <= '0;
            trit_cnt      <= '0;
            byte_cnt      <= '0;
            pack          <= '0;
            comp_data_o   <= '0;
            comp_thr_o    <= '0;
            comp_enable_o <= 1'b0;
        end else begin
            comp_enable_o <= pre_hs;
            if (pre_hs) comp_data_o <= pre_data_i;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        n_groups <= n_groups_i;
                        thr_idx  <= thr_base_i;
                        grp_cnt  <= '0;
                        trit_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                FEED: begin
                    comp_thr_o <= thr_tab[thr_idx];
                    if (pre_valid_i) trit_cnt <= trit_cnt + TW'(1);
                end
                WAIT: begin
                    if (comp_ready_i) begin
                        pack[8*byte_cnt +: 8] <= 8'(comp_data_i);
                        grp_cnt  <= grp_cnt + 16'd1;
                        thr_idx  <= thr_idx + AW'(1);
                        trit_cnt <= '0;
                        if (!(lane_full || last_grp))
                            byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                EMIT: begin
                    if (out_ready_i) begin
                        pack     <= '0;
                        byte_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_threshold_compress_ctrl.sv
// tb_threshold_compress_ctrl: scoreboard bench with a compressor stub,
// directed jobs, backpressure, table wrap and mid-job abort.
module tb_threshold_compress_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cfg_we_i;
    logic [3:0]  cfg_addr_i;
    logic [31:0] cfg_thr_i;
    logic        start_i;
    logic [15:0] n_groups_i;
    logic [3:0]  thr_base_i;
    logic        pre_valid_i;
    logic        pre_ready_o;
    logic [31:0] pre_data_i;
    logic [31:0] comp_data_o;
    logic [31:0] comp_thr_o;
    logic        comp_enable_o;
    logic [7:0]  comp_data_i;
    logic        comp_ready_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic        busy_o;
    logic        done_o;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] thr;
    } feed_t;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } word_t;

    feed_t       exp_q[$];
    word_t       word_q[$];
    logic [7:0]  stub_q[$];
    logic [31:0] tbl [16];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;
    int en_total = 0;
    int en_cnt   = 0;
    int pend     = 0;

    threshold_compress_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_thr_i    (cfg_thr_i),
        .start_i      (start_i),
        .n_groups_i   (n_groups_i),
        .thr_base_i   (thr_base_i),
        .pre_valid_i  (pre_valid_i),
        .pre_ready_o  (pre_ready_o),
        .pre_data_i   (pre_data_i),
        .comp_data_o  (comp_data_o),
        .comp_thr_o   (comp_thr_o),
        .comp_enable_o(comp_enable_o),
        .comp_data_i  (comp_data_i),
        .comp_ready_i (comp_ready_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"},
            {26'd0, out_data_o, pre_ready_o, comp_enable_o,
             out_valid_o, out_last_o, busy_o, done_o}, 64'd0);
        chk({name, "_comp"}, {comp_data_o, comp_thr_o}, 64'd0);
    endtask

    // Compressor stub plus scoreboard monitor
    initial begin
        comp_ready_i = 1'b0;
        comp_data_i  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                en_cnt       = 0;
                pend         = 0;
                comp_ready_i = 1'b0;
            end else begin
                if (comp_ready_i) comp_ready_i = 1'b0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        comp_ready_i = 1'b1;
                        comp_data_i  = stub_q.size() > 0 ?
                                       stub_q.pop_front() : 8'hEE;
                    end
                end
                if (comp_enable_o) begin
                    en_total++;
                    if (exp_q.size() == 0) begin
                        chk("comp_enable_unexpected", 64'd1, 64'd0);
                    end else begin
                        feed_t e;
                        e = exp_q.pop_front();
                        chk("comp_data", comp_data_o, e.data);
                        chk("comp_thr", comp_thr_o, e.thr);
                    end
                    en_cnt++;
                    if (en_cnt == 5) begin
                        en_cnt = 0;
                        pend   = 2;
                    end
                end
                if (out_valid_o && out_ready_i) begin
                    if (word_q.size() == 0) begin
                        chk("out_word_unexpected", 64'd1, 64'd0);
                    end else begin
                        word_t w;
                        w = word_q.pop_front();
                        chk("out_word", {out_last_o, out_data_o},
                            {w.last, w.data});
                    end
                end
                if (done_o) done_cnt++;
            end
        end
    end

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] v);
        cfg_we_i   = 1'b1;
        cfg_addr_i = a;
        cfg_thr_i  = v;
        @(posedge clk); #1;
        cfg_we_i   = 1'b0;
        tbl[a]     = v;
    endtask

    task automatic feed(input int n, input logic [3:0] base, input int gap);
        bit hs;
        for (int i = 0; i < n; i++) begin
            logic [3:0] idx;
            idx         = base + 4'(i / 5);
            pre_valid_i = 1'b1;
            pre_data_i  = 32'hC0DE0000 + 32'(hs_cnt);
            hs          = 1'b0;
            for (int t = 0; t < 200 && !hs; t++) begin
                @(negedge clk);
                hs = pre_ready_o;
                @(posedge clk); #1;
            end
            if (!hs) begin
                chk("pre_handshake_timeout", 64'd1, 64'd0);
                pre_valid_i = 1'b0;
                return;
            end
            hs_cnt++;
            exp_q.push_back('{data: pre_data_i, thr: tbl[idx]});
            pre_valid_i = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
        pre_valid_i = 1'b0;
    endtask

    task automatic hold_out(input int bp, input logic [31:0] w,
                            input logic l);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            ok = out_valid_o;
        end
        if (!ok) begin
            chk("emit_timeout", 64'd1, 64'd0);
            out_ready_i = 1'b1;
            return;
        end
        for (int k = 0; k < bp; k++) begin
            chk("bp_valid", out_valid_o, 1);
            chk("bp_data", out_data_o, w);
            chk("bp_last", out_last_o, l);
            chk("bp_pre_ready", pre_ready_o, 0);
            chk("bp_comp_enable", comp_enable_o, 0);
            if (k < bp - 1) @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready_i = 1'b1;
    endtask

    task automatic poke_busy();
        repeat (3) @(posedge clk);
        #1;
        cfg_we_i   = 1'b1;
        cfg_addr_i = 4'd0;
        cfg_thr_i  = 32'hDEADBEEF;
        start_i    = 1'b1;
        n_groups_i = 16'd9;
        thr_base_i = 4'd7;
        @(posedge clk); #1;
        cfg_we_i   = 1'b0;
        start_i    = 1'b0;
    endtask

    task automatic run_job(input int ng, input logic [3:0] base,
                           input int gap, input int bp,
                           input logic [31:0] bp_w, input bit poke);
        int d0;
        d0 = done_cnt;
        if (bp > 0) out_ready_i = 1'b0;
        n_groups_i = 16'(ng);
        thr_base_i = base;
        start_i    = 1'b1;
        @(posedge clk); #1;
        start_i    = 1'b0;
        fork
            feed(ng * 5, base, gap);
            if (bp > 0) hold_out(bp, bp_w, 1'b1);
            if (poke) poke_busy();
        join
        for (int t = 0; t < 500 && done_cnt == d0; t++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt - d0, 1);
        chk("idle_after_done", busy_o, 0);
    endtask

    // Directed job sequence
    initial begin
        int hs0;
        int en0;
        int d0;
        rst_i       = 1'b1;
        cfg_we_i    = 1'b0;
        cfg_addr_i  = '0;
        cfg_thr_i   = '0;
        start_i     = 1'b0;
        n_groups_i  = '0;
        thr_base_i  = '0;
        pre_valid_i = 1'b0;
        pre_data_i  = '0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) tbl[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_i = 1'b0;
        @(posedge clk); #1;

        cfg_write(4'd0, 32'h0010FFF0);
        cfg_write(4'd1, 32'h0020FFE0);
        for (int i = 2; i < 15; i++)
            cfg_write(4'(i), 32'h00A00F00 | 32'(i));
        cfg_write(4'd15, 32'h0F0F1234);

        stub_q = '{8'hA0, 8'hA1};
        word_q.push_back('{last: 1'b1, data: 32'h0000A1A0});
        run_job(2, 4'd0, 0, 0, 32'h0, 1'b0);

        hs0 = hs_cnt;
        for (int i = 1; i <= 8; i++) stub_q.push_back(8'(i));
        word_q.push_back('{last: 1'b0, data: 32'h04030201});
        word_q.push_back('{last: 1'b1, data: 32'h08070605});
        run_job(8, 4'd0, 0, 0, 32'h0, 1'b0);
        chk("pre_handshakes", hs_cnt - hs0, 40);

        stub_q = '{8'h5C};
        word_q.push_back('{last: 1'b1, data: 32'h0000005C});
        run_job(1, 4'd3, 0, 6, 32'h0000005C, 1'b0);

        en0 = en_total;
        stub_q = '{8'h11, 8'h22};
        word_q.push_back('{last: 1'b1, data: 32'h00002211});
        run_job(2, 4'd4, 1, 0, 32'h0, 1'b0);
        chk("enable_pulses", en_total - en0, 10);

        stub_q = '{8'h33, 8'h44};
        word_q.push_back('{last: 1'b1, data: 32'h00004433});
        run_job(2, 4'd15, 0, 0, 32'h0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("stray_start_busy", busy_o, 0);

        d0 = done_cnt;
        n_groups_i = 16'd2;
        thr_base_i = 4'd1;
        start_i    = 1'b1;
        @(posedge clk); #1;
        start_i    = 1'b0;
        feed(3, 4'd1, 0);
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk_zero("abort");
        rst_i = 1'b0;
        exp_q.delete();
        stub_q.delete();
        for (int i = 0; i < 16; i++) tbl[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle", busy_o, 0);

        stub_q = '{8'h77};
        word_q.push_back('{last: 1'b1, data: 32'h00000077});
        run_job(1, 4'd0, 0, 0, 32'h0, 1'b0);

        chk("exp_q_drained", exp_q.size(), 0);
        chk("word_q_drained", word_q.size(), 0);
        chk("stub_q_drained", stub_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
